// File: rtl/fifo_wr_arbiter_if.sv
// Write-side bundle between NREQ requesters, the round-robin arbiter and the FIFO write port.
// master: the arbiter's view; slave: the requester/FIFO side that drives req, req_data and fifo_full.
interface fifo_wr_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
);
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] req_data;
  logic                  fifo_full;
  logic [NREQ-1:0]       gnt;
  logic                  fifo_wr_en;
  logic [WIDTH-1:0]      fifo_data_in;
  logic [15:0]           wr_count;

  modport master (
    input  req, req_data, fifo_full,
    output gnt, fifo_wr_en, fifo_data_in, wr_count
  );

  modport slave (
    output req, req_data, fifo_full,
    input  gnt, fifo_wr_en, fifo_data_in, wr_count
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NREQ requesters; combinational grant.
// Define FIFO_ARB_LOCK_EN to enable burst lock of up to MAX_BURST beats per owner.
module fifo_wr_arbiter #(
  parameter int NREQ      = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input logic             clk,
  input logic             rst,
  fifo_wr_arbiter_if.master bus
);
  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] sel;
  logic [PTR_W-1:0] cand;
  logic [NREQ-1:0]  gnt_c;
  logic [15:0]      wr_count;

`ifdef FIFO_ARB_LOCK_EN
  typedef enum logic {IDLE, LOCK} state_t;
  state_t           state;
  logic [PTR_W-1:0] owner;
  logic [4:0]       beats;
`endif

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(NREQ - 1)) ? '0 : p + 1'b1;
  endfunction

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    gnt_c = '0;
    sel   = '0;
    cand  = '0;
    if (!rst && !bus.fifo_full) begin
      // Walk from the farthest candidate back to ptr so the closest requester wins.
      for (int k = NREQ - 1; k >= 0; k--) begin
        cand = PTR_W'((int'(ptr) + k) % NREQ);
        if (bus.req[cand]) begin
          gnt_c       = '0;
          gnt_c[cand] = 1'b1;
          sel         = cand;
        end
      end
`ifdef FIFO_ARB_LOCK_EN
      if (state == LOCK) begin
        gnt_c        = '0;
        gnt_c[owner] = bus.req[owner];
        sel          = owner;
      end
`endif
    end
  end

  assign bus.gnt          = gnt_c;
  assign bus.fifo_wr_en   = |gnt_c;
  assign bus.fifo_data_in = (|gnt_c) ? bus.req_data[sel*WIDTH +: WIDTH] : '0;
  assign bus.wr_count     = wr_count;

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr      <= '0;
      wr_count <= '0;
`ifdef FIFO_ARB_LOCK_EN
      state    <= IDLE;
      owner    <= '0;
      beats    <= '0;
`endif
    end else begin
      if (bus.fifo_wr_en) wr_count <= wr_count + 16'd1;
`ifdef FIFO_ARB_LOCK_EN
      case (state)
        IDLE: begin
          if (bus.fifo_wr_en) begin
            owner <= sel;
            beats <= 5'd1;
            if (MAX_BURST > 1) state <= LOCK;
            else               ptr   <= next_ptr(sel);
          end
        end
        LOCK: begin
          // A dropped request ends the burst at once; otherwise it ends on the last allowed beat.
          if (!bus.req[owner]) begin
            state <= IDLE;
            ptr   <= next_ptr(owner);
          end else if (bus.fifo_wr_en) begin
            beats <= beats + 5'd1;
            if (beats + 5'd1 == 5'(MAX_BURST)) begin
              state <= IDLE;
              ptr   <= next_ptr(owner);
            end
          end
        end
        default: state <= IDLE;
      endcase
`else
      if (bus.fifo_wr_en) ptr <= next_ptr(sel);
`endif
    end
  end
endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter that shares the single write port of a synchronous FIFO between `NREQ` requesters. Each requester presents a request and a data word; the arbiter selects at most one per cycle, drives the FIFO's `wr_en`/`data_in`, and never issues a write while the FIFO reports `full`. It sits directly in front of the `fifo` block, in the same clock domain.

## Interface
- `NREQ`, 4, number of requesters (2–8)
- `WIDTH`, 8, data word width; matches the FIFO `WIDTH`
- `MAX_BURST`, 4, maximum beats per locked burst (1–16); used only with `FIFO_ARB_LOCK_EN`

- `clk`  input  1  clock, rising-edge active
- `rst`  input  1  asynchronous, active-high reset
- `req`  input  NREQ  per-requester write request
- `req_data`  input  NREQ*WIDTH  requester i's word at bits [i*WIDTH +: WIDTH]
- `fifo_full`  input  1  `full` flag from the FIFO
- `gnt`  output  NREQ  one-hot grant; the beat transfers at the posedge where `req[i] & gnt[i]`
- `fifo_wr_en`  output  1  write enable to the FIFO; equals `|gnt`
- `fifo_data_in`  output  WIDTH  selected `req_data` slice; all zeros when no grant
- `wr_count`  output  16  total beats written since reset

## Operation
- State: priority pointer `ptr` (0..NREQ-1), `wr_count`, and, with lock, FSM {IDLE, LOCK}, `owner`, `beats`.
- Grant is combinational: with `fifo_full=0` and `rst=0`, grant the first requester with `req` high, searching `ptr`, `ptr+1`, … modulo NREQ.
- `fifo_full=1`: `gnt=0` and `fifo_wr_en=0`. `ptr` and FSM state hold.
- No lock: after a grant to i, `ptr <= (i+1) mod NREQ`. With no grant, `ptr` holds.
- `wr_count` increments on every cycle with `fifo_wr_en=1`. It wraps from 0xFFFF to 0.
- Handshake: a requester holds `req` and its data stable until it sees `gnt` at a posedge. It may drop `req` at any time before that.
- `rst=1` (asynchronous): `ptr=0`, `wr_count=0`, FSM=IDLE, `beats=0`. `gnt`, `fifo_wr_en` and `fifo_data_in` are forced to 0 while `rst` is high.

## Timing
- Zero-cycle latency: `gnt`, `fifo_wr_en` and `fifo_data_in` are valid in the same cycle as `req`/`fifo_full`. The FIFO samples them at the next posedge.
- Throughput: one beat per cycle while the FIFO is not full.
- The arbiter does not predict full. The FIFO's `full` must deassert-before-write semantics (full is registered at the FIFO), so a write issued in the cycle before `full` rises is legal.
- Simultaneous `req` changes and `fifo_full` rising: only the current-cycle values are used. No lookahead.

## Configuration
- `FIFO_ARB_LOCK_EN` defined: burst lock is enabled.
  - In IDLE, a grant to i sets `owner=i` and `beats=1`. If `MAX_BURST>1`, the FSM moves to LOCK; otherwise `ptr` advances as in no-lock mode.
  - In LOCK, only `owner` can be granted. Each granted beat increments `beats`.
  - LOCK exits to IDLE, with `ptr <= (owner+1) mod NREQ`, on the posedge where `beats` reaches `MAX_BURST` on a granted beat.
  - LOCK also exits on any posedge where `req[owner]=0`; no beat is transferred in that cycle.
  - `fifo_full` in LOCK holds the lock and grants nothing.
- Macro undefined: no FSM, `owner` or `beats` logic. The arbiter is pure per-beat round-robin, and `MAX_BURST` is ignored.

## Test plan
- Reset: `rst=1` with `req=4'b1111` -> `gnt=0`, `fifo_wr_en=0`, `fifo_data_in=0`, `wr_count=0`. After release, the first grant goes to requester 0.
- Fair rotation, no lock: `req=4'b1111` held, `fifo_full=0` for 8 cycles -> `gnt` sequence 0001, 0010, 0100, 1000, 0001, …, and `wr_count=8`. With `req=4'b0101` -> 0001, 0100, 0001, 0100.
- Backpressure: drive the real 16-deep `fifo` with `req=4'b1111` -> exactly 16 writes, then `gnt=0` while full. After one FIFO read, exactly one write is issued, to requester `ptr`. No data is lost, checked by the read-back order.
- Burst lock (macro on, `MAX_BURST=4`): `req=4'b0101` held -> grants 0,0,0,0,2,2,2,2,0. A `fifo_full` pulse mid-burst pauses it without switching owner.
- Early release (macro on): requester 0 drops `req` after 2 beats while `req[1]=1` -> the cycle after the drop has no grant (LOCK exit). Requester 1 is granted next, and `ptr` becomes 1 after the exit.
- Reset mid-burst: assert `rst` during the 3rd locked beat -> outputs go to 0 immediately. After release, `ptr=0`, IDLE, and `wr_count=0`.
